// File: rtl/dense_layer_engine.sv
// dense_layer_engine: time-multiplexed dense layer; NUM_LANES MAC lanes sweep the neurons group by group.
// Optional: define DENSE_LAYER_ROUNDING_EN for round-half-up ahead of the fixed-point rescale.
package dense_layer_pkg;
    typedef enum logic [1:0] {
        ACT_NONE    = 2'd0,
        ACT_RELU    = 2'd1,
        ACT_SIGMOID = 2'd2
    } act_e;
endpackage

module dense_lane
    import dense_layer_pkg::*;
#(
    parameter int   W   = 16,
    parameter int   F   = 8,
    parameter int   AW  = 35,
    parameter act_e ACT = ACT_RELU
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_load,
    input  logic                i_acc_en,
    input  logic signed [W-1:0] i_bias,
    input  logic signed [W-1:0] i_x,
    input  logic signed [W-1:0] i_w,
    output logic signed [W-1:0] o_y
);
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic signed [W:0]    HALF    = (W+1)'(1 <<< (F-1));
    localparam logic signed [W:0]    ONE     = (W+1)'(1 <<< F);

    logic signed [AW-1:0]  r_acc;
    logic signed [2*W-1:0] w_prod;
    logic signed [AW-1:0]  w_rnd;
    logic signed [AW-1:0]  w_shr;
    logic signed [W-1:0]   w_sat;
    logic signed [W:0]     w_sig;

    assign w_prod = i_x * i_w;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)
            r_acc <= '0;
        else if (i_load)
            r_acc <= {{(AW-W-F){i_bias[W-1]}}, i_bias, {F{1'b0}}};
        else if (i_acc_en)
            r_acc <= r_acc + {{(AW-2*W){w_prod[2*W-1]}}, w_prod};
    end

`ifdef DENSE_LAYER_ROUNDING_EN
    assign w_rnd = r_acc + AW'(1 <<< (F-1));
`else
    assign w_rnd = r_acc;
`endif
    assign w_shr = w_rnd >>> F;

    always_comb begin
        if (w_shr > SAT_MAX)
            w_sat = {1'b0, {(W-1){1'b1}}};
        else if (w_shr < SAT_MIN)
            w_sat = {1'b1, {(W-1){1'b0}}};
        else
            w_sat = w_shr[W-1:0];
    end

    // hard sigmoid: r/4 + 0.5, one guard bit so the add cannot wrap
    assign w_sig = $signed({{3{w_sat[W-1]}}, w_sat[W-1:2]}) + HALF;

    always_comb begin
        o_y = w_sat;
        case (ACT)
            ACT_RELU: begin
                if (w_sat[W-1])
                    o_y = '0;
            end
            ACT_SIGMOID: begin
                if (w_sig[W])
                    o_y = '0;
                else if (w_sig > ONE)
                    o_y = ONE[W-1:0];
                else
                    o_y = w_sig[W-1:0];
            end
            default: ;
        endcase
    end
endmodule

module dense_layer_engine
    import dense_layer_pkg::*;
#(
    parameter int   NUM_INPUTS     = 120,
    parameter int   NUM_OUTPUTS    = 84,
    parameter int   NUM_LANES      = 4,
    parameter act_e ACTIVATION     = ACT_RELU,
    parameter int   INTEGER_WIDTH  = 8,
    parameter int   FRACTION_WIDTH = 8
) (
    input  logic                                                          i_clock,
    input  logic                                                          i_reset,
    input  logic                                                          i_inputs_ready,
    input  logic [NUM_INPUTS-1:0][INTEGER_WIDTH+FRACTION_WIDTH-1:0]       i_inputs,
    input  logic                                                          i_weight_write,
    input  logic [$clog2(NUM_OUTPUTS*(NUM_INPUTS+1))-1:0]                 i_weight_address,
    input  logic signed [INTEGER_WIDTH+FRACTION_WIDTH-1:0]                i_weight_data,
    output logic                                                          o_busy,
    output logic                                                          o_outputs_ready,
    output logic [NUM_OUTPUTS-1:0][INTEGER_WIDTH+FRACTION_WIDTH-1:0]      o_outputs
);
    localparam int N     = NUM_INPUTS;
    localparam int M     = NUM_OUTPUTS;
    localparam int L     = NUM_LANES;
    localparam int F     = FRACTION_WIDTH;
    localparam int W     = INTEGER_WIDTH + FRACTION_WIDTH;
    localparam int G     = (M + L - 1) / L;
    localparam int DEPTH = M * (N + 1);
    localparam int AD    = $clog2(DEPTH);
    localparam int AW    = 2 * W + $clog2(N) + 1;
    localparam int GW    = (G > 1) ? $clog2(G) : 1;
    localparam int KW    = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_ACT} state_e;

    state_e               r_state, w_next;
    logic [GW-1:0]        r_g;
    logic [KW-1:0]        r_k;
    logic [N-1:0][W-1:0]  r_in;
    logic                 r_ready;
    logic [W-1:0]         r_mem [DEPTH];

    logic                 w_start, w_load, w_acc_en, w_last_g, w_last_k, w_wr_en;
    logic [GW-1:0]        w_load_g;
    logic [L-1:0][W-1:0]  w_y;

    assign w_start  = (r_state == S_IDLE) && i_inputs_ready;
    assign w_last_g = (r_g == GW'(G - 1));
    assign w_last_k = (r_k == KW'(N - 1));
    assign w_load   = w_start || ((r_state == S_ACT) && !w_last_g);
    assign w_acc_en = (r_state == S_ACC);
    assign w_load_g = w_start ? '0 : r_g + 1'b1;
    assign w_wr_en  = i_weight_write && (r_state == S_IDLE) &&
                      ({1'b0, i_weight_address} < (AD+1)'(DEPTH));

    assign o_busy          = (r_state != S_IDLE);
    assign o_outputs_ready = r_ready;

    // Parameter store survives reset so weights loaded once stay valid.
    always_ff @(posedge i_clock) begin
        if (w_wr_en)
            r_mem[i_weight_address] <= i_weight_data;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_inputs_ready) w_next = S_ACC;
            S_ACC:   if (w_last_k)       w_next = S_ACT;
            S_ACT:   w_next = w_last_g ? S_IDLE : S_ACC;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_g     <= '0;
            r_k     <= '0;
            r_in    <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_in    <= i_inputs;
                r_ready <= 1'b0;
                r_g     <= '0;
                r_k     <= '0;
            end
            if (r_state == S_ACC)
                r_k <= w_last_k ? '0 : r_k + 1'b1;
            if (r_state == S_ACT) begin
                if (w_last_g)
                    r_ready <= 1'b1;
                else
                    r_g <= r_g + 1'b1;
            end
        end
    end

    for (genvar j = 0; j < L; j++) begin : g_lane
        logic                w_bvalid, w_wvalid;
        logic [AD-1:0]       w_baddr, w_waddr;
        logic signed [W-1:0] w_bias, w_wt;

        assign w_bvalid = (int'(w_load_g) * L + j) < M;
        assign w_wvalid = (int'(r_g) * L + j) < M;
        assign w_baddr  = AD'((int'(w_load_g) * L + j) * (N + 1) + N);
        assign w_waddr  = AD'((int'(r_g) * L + j) * (N + 1) + int'(r_k));

        // A bias written on the accepting edge must be seen by the load on that same edge.
        always_comb begin
            w_bias = '0;
            if (w_bvalid)
                w_bias = (w_wr_en && (i_weight_address == w_baddr)) ? i_weight_data : r_mem[w_baddr];
        end
        assign w_wt = w_wvalid ? r_mem[w_waddr] : '0;

        dense_lane #(.W(W), .F(F), .AW(AW), .ACT(ACTIVATION)) u_lane (
            .i_clock  (i_clock),
            .i_reset  (i_reset),
            .i_load   (w_load),
            .i_acc_en (w_acc_en),
            .i_bias   (w_bias),
            .i_x      (r_in[r_k]),
            .i_w      (w_wt),
            .o_y      (w_y[j])
        );
    end

    for (genvar n = 0; n < M; n++) begin : g_out
        logic [W-1:0] r_y;

        always_ff @(posedge i_clock or negedge i_reset) begin
            if (!i_reset)
                r_y <= '0;
            else if ((r_state == S_ACT) && (r_g == GW'(n / L)))
                r_y <= w_y[n % L];
        end
        assign o_outputs[n] = r_y;
    end
endmodule

// File: doc/dense_layer_engine.md
# dense_layer_engine

Time-multiplexed fully connected (dense) layer with a configurable number of parallel MAC lanes, selectable activation, and runtime-loadable weights and biases. It replaces fully parallel per-neuron datapaths inside `neural_network` layer chains, trading latency for area. It uses the same `inputs_ready`/`outputs_ready` contract and the same signed fixed-point format, `[INTEGER_WIDTH-1:-FRACTION_WIDTH]`, as the rest of the network.

## Interface
- `NUM_INPUTS`, default 120: input vector length N.
- `NUM_OUTPUTS`, default 84: number of neurons M.
- `NUM_LANES`, default 4: parallel MAC lanes L, with 1 ≤ L ≤ M.
- `ACTIVATION`, default RELU: one of NONE, RELU, SIGMOID (hard sigmoid).
- `INTEGER_WIDTH`, default 8: integer bits, sign bit included.
- `FRACTION_WIDTH`, default 8: fraction bits F.
- `clock`, in, 1: rising-edge clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `inputs_ready`, in, 1: request to start; `inputs` are valid.
- `inputs`, in, N × (INTEGER_WIDTH+F), signed: input vector.
- `weight_write`, in, 1: write strobe for the parameter store.
- `weight_address`, in, clog2(M·(N+1)): address n·(N+1)+k. k<N selects a weight; k=N selects the bias of neuron n.
- `weight_data`, in, INTEGER_WIDTH+F, signed: value to write.
- `busy`, out, 1: high while a computation is in progress.
- `outputs_ready`, out, 1: `outputs` hold a valid result.
- `outputs`, out, M × (INTEGER_WIDTH+F), signed: activated results.

## Operation
- States: IDLE, ACCUMULATE, ACTIVATE. Group count G = ceil(M/L). Lane j of group g computes neuron g·L+j. Lanes with g·L+j ≥ M compute, but their results are discarded.
- IDLE with `inputs_ready`=1: latch `inputs`, clear `outputs_ready`, set g=0 and k=0, load each lane accumulator with bias<<F, then go to ACCUMULATE.
- ACCUMULATE: each cycle, acc += input[k]·weight[n][k] and k++. After k=N−1, go to ACTIVATE.
- ACTIVATE: for each valid lane:
  - compute r = acc >>> F (arithmetic shift), then saturate to [−2^(INTEGER_WIDTH−1), 2^(INTEGER_WIDTH−1) − 2^−F];
  - apply the activation and write `outputs[n]`.
  - If g<G−1: increment g, reload accumulators with bias, set k=0, go to ACCUMULATE. Otherwise set `outputs_ready`=1 and go to IDLE.
- Activations:
  - NONE: identity.
  - RELU: max(0, r).
  - SIGMOID: clamp(r/4 + 0.5, 0, 1.0), where r/4 is an arithmetic shift by 2.
- Widths:
  - Product: 2·(INTEGER_WIDTH+F) bits.
  - Accumulator: product width + clog2(N) + 1. It never overflows; saturation happens only at ACTIVATE.
- Parameter store:
  - Writes are accepted only in IDLE. Writes while `busy`=1 are ignored.
  - The store is not cleared by `reset`.
- `inputs_ready` is ignored while `busy`=1. Held high, it restarts the engine on the first IDLE cycle.
- `outputs` and `outputs_ready` hold their values until the next start is accepted.

## Timing
- Reset values: state IDLE, `busy`=0, `outputs_ready`=0, all `outputs`=0, counters 0.
- Reset mid-operation: the computation is abandoned immediately and all outputs return to their reset values. The parameter store is retained.
- Let the accepting edge be edge 0. Then:
  - `busy` is 1 from edge 0 onward.
  - ACCUMULATE occupies N edges per group; ACTIVATE occupies 1 edge.
  - `outputs_ready` rises and `busy` falls at edge G·(N+1).
- Group g outputs update at edge (g+1)·(N+1). Earlier groups' outputs are visible before `outputs_ready` rises.
- Back-to-back operation: a new start may be accepted on the edge immediately after `outputs_ready` rises.
- Simultaneous `weight_write` and `inputs_ready` in IDLE: the write completes on the accepting edge. Computation reads the parameters after that write.

## Configuration
- `DENSE_LAYER_ROUNDING_EN` defined: ACTIVATE adds 2^(F−1) to acc before the >>>F shift, giving round-half-up.
- Macro undefined: plain truncation toward −∞.
- Saturation and activation behaviour are identical in both modes.

## Test plan
In all scenarios N=4, M=3, L=2, Q8.8 format, so latency is 10 edges.
- NONE, all weights 1.0 (0x0100), biases 0, inputs 0.5 (0x0080) → `outputs` = 2.0 (0x0200) each; `outputs_ready` rises at edge 10.
- RELU, weights −1.0, bias 0.25, inputs 1.0 → pre-activation −3.75 → `outputs` = 0; with weights +1.0 → 4.25 (0x0440).
- NONE, weights 100.0, inputs 100.0 → `outputs` = 0x7FFF; weights −100.0 → 0x8000.
- SIGMOID: bias-only inputs of 0 → 0.5 (0x0080); 8.0 → 1.0 (0x0100); −8.0 → 0.
- Robustness:
  - assert `reset` at edge 5 → `busy`=0, `outputs_ready`=0, `outputs`=0;
  - the next run takes the full 10 edges;
  - `inputs_ready` and `weight_write` pulses while busy have no effect.
- Rounding: one input 2^−8 (0x0001), weight 0.5, all else 0 → output 0x0000 without `DENSE_LAYER_ROUNDING_EN`, 0x0001 with it.
